// File: rtl/ps2_poly_keytracker.sv
// ps2_poly_keytracker: PS/2 receiver with make/break decoding and an N-slot held-note allocator.
module ps2_poly_keytracker #(
    parameter int NUM_VOICES  = 4,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    ps2_clk,
    input  logic                    ps2_dat,
    input  logic                    clear_n,
    output logic [NUM_VOICES-1:0]   key_on,
    output logic [8*NUM_VOICES-1:0] key_code,
    output logic [7:0]              scandata,
    output logic                    frame_valid,
    output logic                    parity_err,
    output logic                    entered,
    output logic [30:0]             keycounter
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0] ck_sync_q, dt_sync_q;
    logic clk_f_q, clk_f_d;
    logic [FW-1:0] flt_q, flt_d;
    state_t state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, sd_q, sd_d;
    logic par_q, par_d, fv_q, fv_d, pe_q, pe_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic brk_q, brk_d, ext_q, ext_d, ent_q, ent_d;
    logic [NUM_VOICES-1:0] on_q, on_d;
    logic [NUM_VOICES-1:0][7:0] code_q, code_d;
    logic [30:0] cnt_q, cnt_d;
    logic ck_s, dt_s, fall, held, done, note;

    assign ck_s = ck_sync_q[1];
    assign dt_s = dt_sync_q[1];

    always_comb begin
        flt_d = '0;
        clk_f_d = clk_f_q;
        if (ck_s != clk_f_q) begin
            flt_d = flt_q + 1'b1;
            if (flt_q == FW'(FILTER_LEN - 1)) begin
                flt_d = '0;
                clk_f_d = ck_s;
            end
        end
        fall = clk_f_q & ~clk_f_d;
    end

    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        shift_d = shift_q;
        par_d = par_q;
        tmo_d = '0;
        sd_d = sd_q;
        fv_d = 1'b0;
        pe_d = 1'b0;
        if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d = dt_s ? IDLE : DATA;
                    bit_d = 3'd0;
                end
                DATA: begin
                    shift_d = {dt_s, shift_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d = dt_s;
                    state_d = STOP;
                end
                default: begin
                    fv_d = dt_s & (^{shift_q, par_q});
                    pe_d = ~fv_d;
                    sd_d = fv_d ? shift_q : sd_q;
                    state_d = IDLE;
                end
            endcase
        end else if (state_q != IDLE) begin
            tmo_d = tmo_q + 1'b1;
            state_d = (tmo_q == TW'(TIMEOUT_CYC - 1)) ? IDLE : state_q;
        end
    end

    assign note = sd_q inside {8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32,
                               8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41, 8'h5A, 8'h29, 8'h16,
                               8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

    always_comb begin
        brk_d = brk_q;
        ext_d = ext_q;
        ent_d = ent_q;
        on_d = on_q;
        code_d = code_q;
        cnt_d = cnt_q;
        held = 1'b0;
        done = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) held |= on_q[i] && code_q[i] == sd_q;
        if (fv_q) begin
            if (sd_q == 8'hF0) brk_d = 1'b1;
            else if (sd_q == 8'hE0) ext_d = 1'b1;
            else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                ent_d = sd_q != 8'h5A;
                if (!ext_q && brk_q) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (!done && on_q[i] && code_q[i] == sd_q) begin
                            done = 1'b1;
                            on_d[i] = 1'b0;
                            code_d[i] = 8'hF0;
                            cnt_d = cnt_q + 31'd1;
                        end
                    end
                end else if (!ext_q && !held && note) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (!done && !on_q[i]) begin
                            done = 1'b1;
                            on_d[i] = 1'b1;
                            code_d[i] = sd_q;
                        end
                    end
                end
            end
        end
        if (!clear_n) begin
            on_d = '0;
            code_d = {NUM_VOICES{8'hF0}};
            brk_d = 1'b0;
            ext_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            ck_sync_q <= 2'b11;
            dt_sync_q <= 2'b11;
            clk_f_q <= 1'b1;
            flt_q <= '0;
            state_q <= IDLE;
            bit_q <= 3'd0;
            shift_q <= 8'h00;
            par_q <= 1'b0;
            tmo_q <= '0;
            sd_q <= 8'h00;
            fv_q <= 1'b0;
            pe_q <= 1'b0;
            brk_q <= 1'b0;
            ext_q <= 1'b0;
            ent_q <= 1'b1;
            on_q <= '0;
            code_q <= {NUM_VOICES{8'hF0}};
            cnt_q <= '0;
        end else begin
            ck_sync_q <= {ck_sync_q[0], ps2_clk};
            dt_sync_q <= {dt_sync_q[0], ps2_dat};
            clk_f_q <= clk_f_d;
            flt_q <= flt_d;
            state_q <= state_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            par_q <= par_d;
            tmo_q <= tmo_d;
            sd_q <= sd_d;
            fv_q <= fv_d;
            pe_q <= pe_d;
            brk_q <= brk_d;
            ext_q <= ext_d;
            ent_q <= ent_d;
            on_q <= on_d;
            code_q <= code_d;
            cnt_q <= cnt_d;
        end
    end

    assign key_on = on_q;
    assign key_code = code_q;
    assign scandata = sd_q;
    assign frame_valid = fv_q;
    assign parity_err = pe_q;
    assign entered = ent_q;
    assign keycounter = cnt_q;
endmodule

// File: doc/ps2_poly_keytracker.md
# ps2_poly_keytracker

Parametrised PS/2 keyboard front end for the synthesizer: receives PS/2 device-to-host frames fully synchronously in the `sys_clk` domain. It checks start, parity and stop bits, decodes make/break/extended sequences, and tracks up to `NUM_VOICES` simultaneously held note keys. It sits between the PS/2 connector pins and the voice/tone generators, replacing the fixed two-key tracker with an N-voice allocator.

## Interface
- `NUM_VOICES`, 4: number of tracked key slots (1..16)
- `FILTER_LEN`, 8: consecutive equal `sys_clk` samples needed to accept a `ps2_clk` level change
- `TIMEOUT_CYC`, 50000: `sys_clk` cycles without a filtered falling edge before a partial frame is aborted
- `sys_clk` in 1: system clock; all logic on rising edge
- `reset` in 1: reset, asynchronous, active-low
- `ps2_clk` in 1: PS/2 clock pin, asynchronous
- `ps2_dat` in 1: PS/2 data pin, asynchronous (input only; no host-to-device transmission)
- `clear_n` in 1: synchronous, active-low; releases all voices
- `key_on` out NUM_VOICES: bit i high while slot i holds a key
- `key_code` out 8*NUM_VOICES: slot i scan code in bits [8i+7:8i]; 8'hF0 when the slot is free
- `scandata` out 8: last valid received byte
- `frame_valid` out 1: one-cycle pulse per accepted frame
- `parity_err` out 1: one-cycle pulse per frame rejected for parity or stop bit
- `entered` out 1: 0 if last valid byte was 8'h5A (Enter), else 1
- `keycounter` out 31: count of voice release events, wraps modulo 2^31

## Operation
- Input conditioning:
  - Both pins pass through 2-FF synchronizers.
  - Filtered clock `clk_f` changes only after `FILTER_LEN` consecutive equal synchronized samples.
  - A falling edge of `clk_f` is the sample event; `ps2_dat` is taken from its synchronized value in the same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: sample event with dat=0 -> DATA (bit count 0). Sample event with dat=1 is ignored.
  - DATA: shift in LSB first; after 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: if stop bit=1 and odd parity over 8 data bits + parity bit holds, pulse `frame_valid` and load `scandata`. Otherwise pulse `parity_err`. Either way -> IDLE.
  - Any non-IDLE state: `TIMEOUT_CYC` cycles with no sample event -> IDLE, no pulse, byte discarded.
- Decoder, acting on each valid byte:
  - 8'hF0: set `brk`.
  - 8'hE0: set `ext`.
  - Other bytes: processed as below, then `brk` and `ext` are cleared.
    - `ext`=1: byte ignored for voices.
    - `brk`=1: release the lowest-index slot whose code equals the byte. Release sets `key_on`=0 and `key_code`=F0, and increments `keycounter`. No match: no change.
    - Make of a note key already held in any slot: no change (typematic repeat).
    - Make of an unheld note key: allocate the lowest-index free slot. No free slot: drop (no stealing).
  - Note keys: 1A 1B 22 23 21 2A 34 32 33 31 3B 3A 41 5A 29 16 1E 26 25 2E 36 3D 3E. All other codes are ignored for voices.
  - `entered` updates on every valid byte that is not F0/E0.
- Clear: `clear_n`=0 frees all slots and clears `brk`/`ext`. It does not touch `keycounter`, `scandata`, or the frame FSM. It has priority over a byte decoded in the same cycle.

## Timing
- Reset values: `key_on`=0, all `key_code`=F0, `scandata`=00, `frame_valid`=0, `parity_err`=0, `entered`=1, `keycounter`=0; FSM in IDLE, `brk`=`ext`=0.
- Reset mid-frame aborts the frame; no pulse is produced.
- Latency from raw pin edge to sample event: 2 sync + `FILTER_LEN` cycles.
- `frame_valid`/`parity_err` and `scandata` update in the cycle of the stop-bit sample event (call it C).
- `key_on`, `key_code`, `entered`, `keycounter` update at C+1.
- Only one slot changes per byte; the release and its `keycounter` increment occur in the same cycle.
- Glitches shorter than `FILTER_LEN` cycles on `ps2_clk` produce no sample event.

## Test plan
- Frame 1A with correct odd parity -> `frame_valid` pulse, `scandata`=1A, slot0 code 1A, `key_on`=0001 at C+1.
- Sequence 1A, 1B, 22, 23, 21 with NUM_VOICES=4 -> slots 1A/1B/22/23, 21 dropped. Then F0 1B -> slot1 freed, `keycounter`=1. Then 21 -> slot1=21.
- Frame with flipped parity bit -> `parity_err` pulse, no `frame_valid`, voices unchanged.
- 8 data bits then clock stops for `TIMEOUT_CYC`+1 cycles -> FSM to IDLE; the next full frame 1A is decoded correctly.
- E0 1A -> no allocation. E0 F0 1A with 1A held -> no release. Then 5A -> `entered`=0, slot allocated. Then 29 -> `entered`=1.
- 4-cycle glitch on `ps2_clk` mid-frame (FILTER_LEN=8) -> ignored, byte correct. `clear_n` pulse while 3 held -> `key_on`=0, `keycounter` unchanged.
